// File: rtl/bcd_to_bnat_seq.sv
// Sequential packed-BCD to natural-binary converter: one digit per clock,
// most-significant first, acc = acc*10 + digit, with a sticky bad-nibble flag.
module bcd_to_bnat_seq #(
   parameter int DIGITS = 2,
   parameter int BIN_W  = 7
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd,
   output logic                  busy,
   output logic                  done,
   output logic                  err,
   output logic [BIN_W-1:0]      bin
);

   localparam int CNT_W = (DIGITS < 2) ? 1 : $clog2(DIGITS + 1);
   localparam logic [BIN_W+3:0] TEN = (BIN_W + 4)'(10);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CONV = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t               state_q;
   logic [4*DIGITS-1:0]  sr_q;
   logic [BIN_W-1:0]     acc_q;
   logic [CNT_W-1:0]     cnt_q;
   logic                 bad_q;
   logic                 busy_q;
   logic                 done_q;
   logic                 err_q;
   logic [BIN_W-1:0]     bin_q;

   logic [3:0]           digit;
   logic [BIN_W+3:0]     accWide;
   logic [BIN_W-1:0]     acc_d;
   logic                 bad_d;

   // Widen before multiplying so the *10 step cannot wrap mid-computation
   always_comb begin
      digit   = sr_q[4*DIGITS-1 -: 4];
      accWide = ({4'b0000, acc_q} * TEN) + {{BIN_W{1'b0}}, digit};
      acc_d   = accWide[BIN_W-1:0];
      bad_d   = bad_q | (digit > 4'd9);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         sr_q    <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         bad_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         bin_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  sr_q    <= bcd;
                  acc_q   <= '0;
                  cnt_q   <= CNT_W'(DIGITS);
                  bad_q   <= 1'b0;
                  err_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= CONV;
               end
            end
            CONV: begin
               acc_q <= acc_d;
               sr_q  <= sr_q << 4;
               cnt_q <= cnt_q - CNT_W'(1);
               bad_q <= bad_d;
               if (cnt_q == CNT_W'(1)) begin
                  bin_q   <= bad_d ? '0 : acc_d;
                  err_q   <= bad_d;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= DONE;
               end
            end
            DONE: begin
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign err  = err_q;
   assign bin  = bin_q;

endmodule

// File: tb/tb_bcd_to_bnat_seq.sv
// Self-checking bench for bcd_to_bnat_seq: a 2-digit and a 3-digit instance
// driven by directed vector tables, hand-written corner sequences and a sweep.
module tb_bcd_to_bnat_seq;

   logic        clk;
   logic        rst;

   logic        start2;
   logic [7:0]  bcd2;
   logic        busy2, done2, err2;
   logic [6:0]  bin2;

   logic        start3;
   logic [11:0] bcd3;
   logic        busy3, done3, err3;
   logic [9:0]  bin3;

   int checks;
   int errors;

   bcd_to_bnat_seq #(.DIGITS(2), .BIN_W(7)) dut2 (
      .clk(clk), .rst(rst), .start(start2), .bcd(bcd2),
      .busy(busy2), .done(done2), .err(err2), .bin(bin2)
   );

   bcd_to_bnat_seq #(.DIGITS(3), .BIN_W(10)) dut3 (
      .clk(clk), .rst(rst), .start(start3), .bcd(bcd3),
      .busy(busy3), .done(done3), .err(err3), .bin(bin3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] bcd;
      logic [6:0] bin;
      logic       err;
   } vec2_t;

   typedef struct {
      logic [11:0] bcd;
      logic [9:0]  bin;
      logic        err;
   } vec3_t;

   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
      end
   endtask

   // One full 2-digit conversion with per-edge latency checks
   task automatic applyStimulus(input logic [7:0] b, input logic [6:0] eb, input logic ee);
      @(negedge clk);
      start2 = 1'b1;
      bcd2   = b;
      @(posedge clk); #1;
      checkOutput("busy_e0", 16'(busy2), 16'd1);
      checkOutput("err_cleared_e0", 16'(err2), 16'd0);
      start2 = 1'b0;
      bcd2   = ~b;
      @(posedge clk); #1;
      checkOutput("busy_e1", 16'(busy2), 16'd1);
      checkOutput("done_e1", 16'(done2), 16'd0);
      @(posedge clk); #1;
      checkOutput("busy_e2", 16'(busy2), 16'd0);
      checkOutput("done_e2", 16'(done2), 16'd1);
      checkOutput("bin", 16'(bin2), 16'(eb));
      checkOutput("err", 16'(err2), 16'(ee));
      @(posedge clk); #1;
      checkOutput("done_e3", 16'(done2), 16'd0);
      checkOutput("bin_held", 16'(bin2), 16'(eb));
   endtask

   task automatic applyStimulus3(input logic [11:0] b, input logic [9:0] eb, input logic ee);
      @(negedge clk);
      start3 = 1'b1;
      bcd3   = b;
      @(posedge clk); #1;
      start3 = 1'b0;
      bcd3   = 12'h000;
      checkOutput("d3_busy_e0", 16'(busy3), 16'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("d3_done_e2", 16'(done3), 16'd0);
      checkOutput("d3_busy_e2", 16'(busy3), 16'd1);
      @(posedge clk); #1;
      checkOutput("d3_done_e3", 16'(done3), 16'd1);
      checkOutput("d3_bin", 16'(bin3), 16'(eb));
      checkOutput("d3_err", 16'(err3), 16'(ee));
      @(posedge clk); #1;
      checkOutput("d3_done_e4", 16'(done3), 16'd0);
   endtask

   vec2_t vec2 [10];
   vec3_t vec3 [4];

   initial begin
      logic [3:0] hi, lo;
      logic       mErr;
      logic [6:0] mBin;

      checks = 0;
      errors = 0;
      start2 = 1'b0; bcd2 = '0;
      start3 = 1'b0; bcd3 = '0;

      vec2[0] = '{8'h42, 7'd42, 1'b0};
      vec2[1] = '{8'h99, 7'd99, 1'b0};
      vec2[2] = '{8'h00, 7'd0,  1'b0};
      vec2[3] = '{8'h1A, 7'd0,  1'b1};
      vec2[4] = '{8'h07, 7'd7,  1'b0};
      vec2[5] = '{8'h50, 7'd50, 1'b0};
      vec2[6] = '{8'hA0, 7'd0,  1'b1};
      vec2[7] = '{8'h09, 7'd9,  1'b0};
      vec2[8] = '{8'hFF, 7'd0,  1'b1};
      vec2[9] = '{8'h81, 7'd81, 1'b0};

      vec3[0] = '{12'h999, 10'd999, 1'b0};
      vec3[1] = '{12'h255, 10'd255, 1'b0};
      vec3[2] = '{12'h9F0, 10'd0,   1'b1};
      vec3[3] = '{12'h100, 10'd100, 1'b0};

      rst = 1'b1;
      #12;
      checkOutput("rst_busy", 16'(busy2), 16'd0);
      checkOutput("rst_done", 16'(done2), 16'd0);
      checkOutput("rst_err",  16'(err2),  16'd0);
      checkOutput("rst_bin",  16'(bin2),  16'd0);
      checkOutput("rst_bin3", 16'(bin3),  16'd0);
      @(negedge clk);
      rst = 1'b0;

      for (int i = 0; i < 10; i++)
         applyStimulus(vec2[i].bcd, vec2[i].bin, vec2[i].err);

      for (int i = 0; i < 4; i++)
         applyStimulus3(vec3[i].bcd, vec3[i].bin, vec3[i].err);

      // Start held high throughout; bcd changes during the first conversion
      @(negedge clk);
      start2 = 1'b1;
      bcd2   = 8'h15;
      @(posedge clk); #1;
      checkOutput("hold_busy_e0", 16'(busy2), 16'd1);
      bcd2 = 8'h88;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("hold_done1", 16'(done2), 16'd1);
      checkOutput("hold_bin1", 16'(bin2), 16'd15);
      @(posedge clk); #1;
      checkOutput("hold_ignored_in_done", 16'(busy2), 16'd0);
      checkOutput("hold_done_low", 16'(done2), 16'd0);
      @(posedge clk); #1;
      checkOutput("hold_accept2", 16'(busy2), 16'd1);
      checkOutput("hold_bin_kept", 16'(bin2), 16'd15);
      start2 = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      checkOutput("hold_done2", 16'(done2), 16'd1);
      checkOutput("hold_bin2", 16'(bin2), 16'd88);
      @(posedge clk); #1;

      // Asynchronous reset in the middle of a conversion
      applyStimulus(8'h1A, 7'd0, 1'b1);
      applyStimulus(8'h99, 7'd99, 1'b0);
      @(negedge clk);
      start2 = 1'b1;
      bcd2   = 8'h73;
      @(posedge clk); #1;
      start2 = 1'b0;
      checkOutput("mid_busy", 16'(busy2), 16'd1);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("arst_busy", 16'(busy2), 16'd0);
      checkOutput("arst_done", 16'(done2), 16'd0);
      checkOutput("arst_err",  16'(err2),  16'd0);
      checkOutput("arst_bin",  16'(bin2),  16'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checkOutput("arst_no_done", 16'(done2), 16'd0);
         checkOutput("arst_no_resume", 16'(busy2), 16'd0);
      end
      applyStimulus(8'h73, 7'd73, 1'b0);

      // Exhaustive sweep against a digit-wise reference model
      for (int c = 0; c < 256; c++) begin
         hi   = 4'(c >> 4);
         lo   = 4'(c);
         mErr = (hi > 4'd9) || (lo > 4'd9);
         mBin = mErr ? 7'd0 : 7'((int'(hi) * 10) + int'(lo));
         applyStimulus(8'(c), mBin, mErr);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout actual=running required=finished");
      $fatal(1, "[TB] timeout");
   end

endmodule
